eq_streak_tracker: RTL
======================

# eq_streak_tracker

Registered consumer of the 3-bit equality comparison. Each valid input pair (A, B) is compared. The block then does four things:
- registers the equal, not-equal and selected-value results;
- counts consecutive matches;
- declares lock after a programmable run of matches, and flags loss of lock;
- keeps a saturating total mismatch count.

It sits directly downstream of the combinational comparator stage and feeds the status/control logic.

## Interface
- W, 3: width of compared operands.
- LOCK_COUNT, 4: consecutive matches required to lock; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of streak and mismatch counters.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A/B pair valid this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- clear  in  1  synchronous clear of counters and state machine.
- out_valid  out  1  registered copy of accepted in_valid.
- eq  out  1  registered (A == B) of last accepted sample.
- ne  out  1  registered (A != B) of last accepted sample; always the complement of eq when out_valid=1.
- sel_val  out  W  registered A if equal, else B.
- streak  out  CNT_W  consecutive-match count, saturating.
- mismatch_cnt  out  CNT_W  total mismatches since reset/clear, saturating.
- locked  out  1  high in LOCKED state.
- lock_lost  out  1  one-cycle pulse on the LOCKED->LOST transition.

## Operation
- Reset (rst_n=0, asynchronous): all outputs are 0, streak=0, mismatch_cnt=0, state=SEARCH.
- Accepted sample: in_valid=1 and clear=0. There is no backpressure; every accepted sample is processed.
- On an accepted sample:
  - eq/ne/sel_val update as in the comparator.
  - match: streak <= min(streak+1, 2^CNT_W-1).
  - mismatch: streak <= 0; mismatch_cnt <= min(mismatch_cnt+1, 2^CNT_W-1).
- When in_valid=0: eq/ne/sel_val/streak/mismatch_cnt hold; out_valid <= 0; state holds.
- State machine (transitions only on accepted samples):
  - SEARCH: match that makes the next streak equal LOCK_COUNT -> LOCKED. Otherwise stay.
  - LOCKED: match -> stay (streak keeps counting to saturation). Mismatch -> LOST, lock_lost=1 for exactly one cycle.
  - LOST: match -> SEARCH (streak=1); if LOCK_COUNT=1, go to LOCKED directly. Mismatch -> SEARCH.
  - The encoding is not architecturally visible; only locked and lock_lost are.
- locked = (state == LOCKED), registered.
- clear=1:
  - next edge: streak=0, mismatch_cnt=0, state=SEARCH, locked=0, lock_lost=0, out_valid=0.
  - eq/ne/sel_val hold.
  - The coincident in_valid sample is discarded (clear wins).
- Saturation: counters stick at all-ones and never wrap to 0.

## Timing
- Latency is 1 cycle: a sample at edge k appears on all outputs after edge k.
- Back-to-back samples are accepted every cycle; throughput is 1 per clock.
- locked rises on the same edge as the LOCK_COUNT-th consecutive match. It falls on the edge of the first mismatch, which is the same edge lock_lost rises.
- lock_lost is high for one cycle only, even if in_valid stays low afterward.
- Reset asserted mid-run clears all state immediately, without waiting for a clock. The first sample after reset deassertion is processed normally.

## Test plan
- Reset check: hold rst_n=0 and drive random inputs -> all outputs stay 0. Release reset and send one pair (5,5) -> out_valid=1, eq=1, ne=0, sel_val=5, streak=1, locked=0.
- Lock acquisition: send 4 valid matches (3,3) back-to-back -> locked=1 after the 4th edge with streak=4. A gap (in_valid=0) between matches 2 and 3 -> streak holds at 2, out_valid=0 during the gap, lock still reached on the 4th match.
- Loss of lock: from LOCKED, send (2,6) -> locked=0, lock_lost=1 for one cycle, sel_val=6, ne=1, streak=0, mismatch_cnt incremented. Then (1,1) -> state SEARCH, streak=1.
- Saturation: CNT_W=3 with 9 consecutive mismatches -> mismatch_cnt=7 and holds at 7. With 9 matches -> streak=7 and holds; locked stays 1.
- Clear priority: assert clear together with in_valid and pair (4,0) while locked with mismatch_cnt=3 -> next cycle streak=0, mismatch_cnt=0, locked=0, out_valid=0, eq/ne/sel_val unchanged.
- Async reset mid-stream: pull rst_n low between clock edges while locked=1 -> locked and counters go to 0 before the next edge.

Source files
------------

// File: rtl/eq_streak_tracker.sv
// Registered consumer of an A/B equality comparison: latches eq/ne/selected
// value, tracks consecutive matches, declares/loses lock and counts mismatches.
module eq_streak_tracker #(
  parameter int W          = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             clear,
  output logic             out_valid,
  output logic             eq,
  output logic             ne,
  output logic [W-1:0]     sel_val,
  output logic [CNT_W-1:0] streak,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             locked,
  output logic             lock_lost
);

  // Handshake: a sample is accepted when in_valid=1 and clear=0; there is no
  // ready, every accepted sample is consumed and reported one cycle later.

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_LOST   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             eq_q, eq_d;
  logic             ne_q, ne_d;
  logic [W-1:0]     sel_val_q, sel_val_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             locked_q, locked_d;
  logic             lock_lost_q, lock_lost_d;

  logic             match;
  logic [CNT_W-1:0] streak_inc;
  logic [CNT_W-1:0] mismatch_inc;

  assign match        = (in_a == in_b);
  assign streak_inc   = (&streak_q) ? streak_q : streak_q + 1'b1;
  assign mismatch_inc = (&mismatch_cnt_q) ? mismatch_cnt_q : mismatch_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    out_valid_d    = 1'b0;
    eq_d           = eq_q;
    ne_d           = ne_q;
    sel_val_d      = sel_val_q;
    streak_d       = streak_q;
    mismatch_cnt_d = mismatch_cnt_q;
    lock_lost_d    = 1'b0;

    if (clear) begin
      // Clear wins over a coincident sample; comparator results are kept.
      state_d        = ST_SEARCH;
      streak_d       = '0;
      mismatch_cnt_d = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      eq_d        = match;
      ne_d        = ~match;
      sel_val_d   = match ? in_a : in_b;
      if (match) begin
        streak_d = streak_inc;
        // From LOST the streak restarts at 1, so this also covers LOCK_COUNT=1.
        if (state_q != ST_LOCKED && streak_inc == CNT_W'(LOCK_COUNT))
          state_d = ST_LOCKED;
        else if (state_q == ST_LOST)
          state_d = ST_SEARCH;
      end else begin
        streak_d       = '0;
        mismatch_cnt_d = mismatch_inc;
        case (state_q)
          ST_LOCKED: begin
            state_d     = ST_LOST;
            lock_lost_d = 1'b1;
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SEARCH;
      out_valid_q    <= 1'b0;
      eq_q           <= 1'b0;
      ne_q           <= 1'b0;
      sel_val_q      <= '0;
      streak_q       <= '0;
      mismatch_cnt_q <= '0;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      eq_q           <= eq_d;
      ne_q           <= ne_d;
      sel_val_q      <= sel_val_d;
      streak_q       <= streak_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      locked_q       <= locked_d;
      lock_lost_q    <= lock_lost_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign eq           = eq_q;
  assign ne           = ne_q;
  assign sel_val      = sel_val_q;
  assign streak       = streak_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign locked       = locked_q;
  assign lock_lost    = lock_lost_q;

endmodule
